uart_cmd_responder: RTL and testbench
=====================================

# uart_cmd_responder

Command responder on the far side of the UART byte link: consumes the received byte stream, decodes fixed-length request frames from a host, performs register reads/writes on a simple register bus, and returns a response frame through the UART transmitter byte interface. Sits between the UART top level (rx_data/rx_data_valid in, tx_data/tx_data_valid/tx_ready out) and the design's control/status registers.

## Interface
- TIMEOUT, 100000: max clk cycles allowed between bytes of one request before the partial frame is discarded (1 ms at 100 MHz).
- clk  input  1  system clock, 100 MHz.
- reset_n  input  1  asynchronous, active-low reset.
- rx_data_valid  input  1  one-cycle pulse: rx_data holds a received byte.
- rx_data  input  8  received byte.
- tx_ready  input  1  UART transmitter idle; drops the cycle after it accepts a byte.
- tx_data_valid  output  1  one-cycle pulse offering tx_data.
- tx_data  output  8  byte to transmit.
- reg_addr  output  8  register bus address.
- reg_wdata  output  8  register write data.
- reg_wr_en  output  1  one-cycle write strobe.
- reg_rd_en  output  1  one-cycle read strobe.
- reg_rdata  input  8  read data, valid the cycle after reg_rd_en.
- busy  output  1  high from first request byte after sync until last response byte accepted.
- frame_drop  output  1  one-cycle pulse when a partial request is discarded by timeout.

## Operation
- Request frame: 0xA5 (sync), CMD, ADDR, DATA, CSUM; CSUM = CMD ^ ADDR ^ DATA. DATA present for every command (ignored for read).
- CMD 0x01 = write reg[ADDR] <= DATA; CMD 0x02 = read reg[ADDR].
- Response frame: 0x5A, STATUS, RDATA, CSUM = STATUS ^ RDATA.
- STATUS: 0x00 OK; 0x01 checksum error; 0x02 unknown command. Checksum checked first. RDATA = read value for OK reads, else 0x00.
- No register access on any error status.
- States: IDLE, CMD, ADDR, DATA, CSUM, EXEC, RD_WAIT, SEND, GAP.
- IDLE: bytes other than 0xA5 ignored; 0xA5 -> CMD.
- CMD/ADDR/DATA/CSUM: each rx byte latched, advance; 0xA5 inside a frame is ordinary data (no resync).
- CSUM byte -> EXEC. EXEC (one cycle): drive reg_wr_en or reg_rd_en if OK; read -> RD_WAIT, else -> SEND. RD_WAIT latches reg_rdata, -> SEND.
- SEND: when tx_ready=1 assert tx_data_valid with response byte k (k=0..3), -> GAP. GAP (one cycle, ignores tx_ready) -> SEND with k+1, or IDLE after k=3.
- rx bytes arriving in EXEC, RD_WAIT, SEND, GAP are dropped silently.
- Timeout counter: cleared on each accepted rx byte, counts in CMD..CSUM; reaching TIMEOUT -> IDLE, frame_drop pulse, no response. Counter width = clog2(TIMEOUT+1).

## Timing
- Reset (async assert, sync release): state IDLE; tx_data_valid, reg_wr_en, reg_rd_en, busy, frame_drop = 0; tx_data, reg_addr, reg_wdata = 0x00.
- reg_addr/reg_wdata stable from EXEC until next frame's EXEC.
- CSUM byte pulse at cycle N: EXEC at N+1 (strobe here); write/error: first tx_data_valid earliest N+2; read: reg_rdata sampled at N+2, first tx_data_valid earliest N+3.
- tx_data_valid never on consecutive cycles; tx_data held stable while tx_data_valid=1.
- Timeout and rx byte in same cycle: byte wins, counter clears.
- busy rises the cycle after the sync byte, falls the cycle after the fourth tx_data_valid.
- Reset mid-frame or mid-response: abort immediately, no further tx_data_valid, strobes low.

## Test plan
- Write: A5 01 10 3C 2D -> reg_wr_en one cycle, reg_addr=0x10, reg_wdata=0x3C; response 5A 00 00 00.
- Read: A5 02 20 00 22, reg_rdata=0x77 -> reg_rd_en one cycle, addr 0x20; response 5A 00 77 77.
- Bad checksum: A5 01 10 3C 00 -> no strobes; response 5A 01 00 01.
- Bad command: A5 07 00 00 07 -> no strobes; response 5A 02 00 02.
- Timeout: A5 01 then silence TIMEOUT cycles -> frame_drop pulse, busy low, no tx; following valid frame processed normally.
- tx_ready held low 50 cycles during response, extra rx bytes injected, junk bytes 00 FF before sync -> bytes ignored, 4 response bytes delivered in order, no back-to-back valids.

Source files
------------

// File: rtl/uart_cmd_responder_if.sv
// Byte-link and register-bus signals between the command responder and its
// surroundings (UART receiver/transmitter, control/status register block).
interface uart_cmd_responder_if;
   logic       rx_data_valid;
   logic [7:0] rx_data;
   logic       tx_ready;
   logic       tx_data_valid;
   logic [7:0] tx_data;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_wr_en;
   logic       reg_rd_en;
   logic [7:0] reg_rdata;
   logic       busy;
   logic       frame_drop;

   // Responder side: consumes rx bytes and read data, drives tx and the register bus.
   modport master (
      input  rx_data_valid, rx_data, tx_ready, reg_rdata,
      output tx_data_valid, tx_data, reg_addr, reg_wdata, reg_wr_en, reg_rd_en,
             busy, frame_drop
   );

   // Environment side: UART and register block.
   modport slave (
      output rx_data_valid, rx_data, tx_ready, reg_rdata,
      input  tx_data_valid, tx_data, reg_addr, reg_wdata, reg_wr_en, reg_rd_en,
             busy, frame_drop
   );
endinterface

// File: rtl/uart_cmd_responder.sv
// UART command responder: decodes 5-byte request frames (A5 CMD ADDR DATA CSUM),
// performs one register write or read, and answers with a 4-byte response
// frame (5A STATUS RDATA CSUM). Partial requests are discarded after TIMEOUT
// idle cycles between bytes.
module uart_cmd_responder #(
   parameter int TIMEOUT = 100000
) (
   input logic                  clk,
   input logic                  reset_n,
   uart_cmd_responder_if.master bus
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

   localparam logic [7:0] SYNC_REQ    = 8'hA5;
   localparam logic [7:0] SYNC_RSP    = 8'h5A;
   localparam logic [7:0] CMD_WR      = 8'h01;
   localparam logic [7:0] CMD_RD      = 8'h02;
   localparam logic [7:0] ST_OK       = 8'h00;
   localparam logic [7:0] ST_CSUM_ERR = 8'h01;
   localparam logic [7:0] ST_CMD_ERR  = 8'h02;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DATA,
      S_CSUM,
      S_EXEC,
      S_RD_WAIT,
      S_SEND,
      S_GAP
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       cmd_q, cmd_d;
   logic [7:0]       addr_q, addr_d;
   logic [7:0]       data_q, data_d;
   logic [7:0]       status_q, status_d;
   logic [7:0]       rdata_q, rdata_d;
   logic [7:0]       reg_addr_q, reg_addr_d;
   logic [7:0]       reg_wdata_q, reg_wdata_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             in_frame;
   logic [7:0]       csum_calc;
   logic [7:0]       resp_byte;
   logic             tx_valid;
   logic             wr_en;
   logic             rd_en;
   logic             drop;

   // State and datapath registers; reset returns to IDLE with a cleared bus.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cmd_q       <= 8'h00;
         addr_q      <= 8'h00;
         data_q      <= 8'h00;
         status_q    <= 8'h00;
         rdata_q     <= 8'h00;
         reg_addr_q  <= 8'h00;
         reg_wdata_q <= 8'h00;
         idx_q       <= 2'd0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         status_q    <= status_d;
         rdata_q     <= rdata_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
      end
   end

   // Response byte selected by the send index.
   always_comb begin
      resp_byte = SYNC_RSP;
      case (idx_q)
         2'd0:    resp_byte = SYNC_RSP;
         2'd1:    resp_byte = status_q;
         2'd2:    resp_byte = rdata_q;
         default: resp_byte = status_q ^ rdata_q;
      endcase
   end

   // Next-state logic: frame capture, inter-byte timeout, execute and response sequencing.
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      addr_d      = addr_q;
      data_d      = data_q;
      status_d    = status_q;
      rdata_d     = rdata_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      tx_valid    = 1'b0;
      wr_en       = 1'b0;
      rd_en       = 1'b0;
      drop        = 1'b0;
      csum_calc   = cmd_q ^ addr_q ^ data_q;
      in_frame    = (state_q == S_CMD) || (state_q == S_ADDR) ||
                    (state_q == S_DATA) || (state_q == S_CSUM);

      // A byte arriving in the same cycle the timeout expires keeps the frame alive.
      if (in_frame) begin
         if (bus.rx_data_valid) begin
            cnt_d = '0;
         end else if (cnt_q == TIMEOUT_CNT) begin
            drop    = 1'b1;
            state_d = S_IDLE;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (bus.rx_data_valid && (bus.rx_data == SYNC_REQ)) begin
               state_d = S_CMD;
               cnt_d   = '0;
            end
         end
         S_CMD: begin
            if (bus.rx_data_valid) begin
               cmd_d   = bus.rx_data;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            if (bus.rx_data_valid) begin
               addr_d  = bus.rx_data;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (bus.rx_data_valid) begin
               data_d  = bus.rx_data;
               state_d = S_CSUM;
            end
         end
         S_CSUM: begin
            if (bus.rx_data_valid) begin
               // Checksum errors take precedence over unknown commands.
               if (bus.rx_data != csum_calc) begin
                  status_d = ST_CSUM_ERR;
               end else if ((cmd_q != CMD_WR) && (cmd_q != CMD_RD)) begin
                  status_d = ST_CMD_ERR;
               end else begin
                  status_d = ST_OK;
               end
               reg_addr_d  = addr_q;
               reg_wdata_d = data_q;
               rdata_d     = 8'h00;
               idx_d       = 2'd0;
               state_d     = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_SEND;
            if (status_q == ST_OK) begin
               if (cmd_q == CMD_RD) begin
                  rd_en   = 1'b1;
                  state_d = S_RD_WAIT;
               end else begin
                  wr_en = 1'b1;
               end
            end
         end
         S_RD_WAIT: begin
            rdata_d = bus.reg_rdata;
            state_d = S_SEND;
         end
         S_SEND: begin
            if (bus.tx_ready) begin
               tx_valid = 1'b1;
               state_d  = S_GAP;
            end
         end
         S_GAP: begin
            if (idx_q == 2'd3) begin
               state_d = S_IDLE;
            end else begin
               idx_d   = idx_q + 2'd1;
               state_d = S_SEND;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.tx_data_valid = tx_valid;
   assign bus.tx_data       = (state_q == S_SEND) ? resp_byte : 8'h00;
   assign bus.reg_addr      = reg_addr_q;
   assign bus.reg_wdata     = reg_wdata_q;
   assign bus.reg_wr_en     = wr_en;
   assign bus.reg_rd_en     = rd_en;
   assign bus.frame_drop    = drop;
   // The GAP after the last response byte already counts as idle.
   assign bus.busy          = (state_q != S_IDLE) &&
                              !((state_q == S_GAP) && (idx_q == 2'd3));

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder: directed frames from the test
// plan plus randomized frames, checked against a frame-level reference model.
module tb_uart_cmd_responder;

   localparam int TO = 200;

   logic clk;
   logic reset_n;

   uart_cmd_responder_if bus ();

   uart_cmd_responder #(.TIMEOUT(TO)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- register block emulation and reference memory ----------------
   logic [7:0] env_mem [256];
   logic [7:0] mdl_mem [256];

   always @(posedge clk) begin
      if (bus.reg_wr_en) env_mem[bus.reg_addr] <= bus.reg_wdata;
      if (bus.reg_rd_en) bus.reg_rdata <= env_mem[bus.reg_addr];
   end

   // ---------------- UART transmitter emulation ----------------
   bit hold_low = 0;
   int tx_busy_cnt = 0;
   logic tx_acc;

   initial begin
      bus.tx_ready = 1'b1;
      forever begin
         @(negedge clk);
         tx_acc = bus.tx_data_valid;
         @(posedge clk);
         #1;
         if (tx_acc) tx_busy_cnt = $urandom_range(1, 4);
         else if (tx_busy_cnt > 0) tx_busy_cnt--;
         bus.tx_ready = !hold_low && (tx_busy_cnt == 0);
      end
   end

   // ---------------- output monitor ----------------
   logic [7:0] tx_q[$];
   int         tx_cyc_q[$];
   logic       tx_busy_q[$];
   logic [7:0] wr_a_q[$];
   logic [7:0] wr_d_q[$];
   int         wr_c_q[$];
   logic [7:0] rd_a_q[$];
   int         rd_c_q[$];
   int         drop_cnt = 0;
   int         drop_cyc = 0;
   logic       prev_valid = 1'b0;

   always @(negedge clk) begin
      if (bus.tx_data_valid) begin
         check_eq("tx_back_to_back", {31'd0, prev_valid}, 32'd0);
         tx_q.push_back(bus.tx_data);
         tx_cyc_q.push_back(cyc);
         tx_busy_q.push_back(bus.busy);
      end
      if (bus.reg_wr_en) begin
         wr_a_q.push_back(bus.reg_addr);
         wr_d_q.push_back(bus.reg_wdata);
         wr_c_q.push_back(cyc);
      end
      if (bus.reg_rd_en) begin
         rd_a_q.push_back(bus.reg_addr);
         rd_c_q.push_back(cyc);
      end
      if (bus.frame_drop) begin
         drop_cnt++;
         drop_cyc = cyc;
      end
      prev_valid = bus.tx_data_valid;
   end

   // ---------------- reference model ----------------
   // Response and side effects of one complete request frame.
   function automatic void model_frame(input logic [7:0] cmd, input logic [7:0] addr,
                                       input logic [7:0] data, input logic [7:0] csum,
                                       output logic [7:0] st, output logic [7:0] rd,
                                       output bit do_wr, output bit do_rd);
      if ((cmd ^ addr ^ data) != csum)       st = 8'h01;
      else if (cmd != 8'h01 && cmd != 8'h02) st = 8'h02;
      else                                   st = 8'h00;
      do_wr = (st == 8'h00) && (cmd == 8'h01);
      do_rd = (st == 8'h00) && (cmd == 8'h02);
      rd    = do_rd ? mdl_mem[addr] : 8'h00;
      if (do_wr) mdl_mem[addr] = data;
   endfunction

   // ---------------- stimulus ----------------
   int         last_cyc = 0;
   logic [7:0] resp [4];

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(posedge clk);
      #1;
      bus.rx_data_valid = 1'b1;
      bus.rx_data       = b;
      last_cyc          = cyc;
      @(posedge clk);
      #1;
      bus.rx_data_valid = 1'b0;
      repeat (gap) @(posedge clk);
   endtask

   function automatic int pick_gap(input int g);
      return (g < 0) ? int'($urandom_range(0, 2)) : g;
   endfunction

   task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr,
                            input logic [7:0] data, input logic [7:0] csum,
                            input bit junk, input bit stall, input int g);
      logic [7:0] st, rd;
      logic [7:0] exp [4];
      bit         dw, dr;
      int         csum_cyc, drop_base, i;
      model_frame(cmd, addr, data, csum, st, rd, dw, dr);
      exp[0] = 8'h5A; exp[1] = st; exp[2] = rd; exp[3] = st ^ rd;
      tx_q.delete(); tx_cyc_q.delete(); tx_busy_q.delete();
      wr_a_q.delete(); wr_d_q.delete(); wr_c_q.delete();
      rd_a_q.delete(); rd_c_q.delete();
      drop_base = drop_cnt;
      if (junk) begin
         send_byte(8'h00, pick_gap(g));
         send_byte(8'hFF, pick_gap(g));
      end
      send_byte(8'hA5, pick_gap(g));
      send_byte(cmd, pick_gap(g));
      send_byte(addr, pick_gap(g));
      if (stall) hold_low = 1;
      send_byte(data, pick_gap(g));
      send_byte(csum, 0);
      csum_cyc = last_cyc;
      // Wait for the response while injecting stray rx bytes.
      i = 0;
      while (tx_q.size() < 4 && i < 600) begin
         @(posedge clk);
         #1;
         bus.rx_data_valid = 1'b0;
         if (stall && i == 50) hold_low = 0;
         if (tx_q.size() < 4 && $urandom_range(0, 2) == 0) begin
            bus.rx_data_valid = 1'b1;
            bus.rx_data       = 8'($urandom);
         end
         i++;
      end
      bus.rx_data_valid = 1'b0;
      hold_low = 0;
      check_eq("resp_count", tx_q.size(), 4);
      @(negedge clk);
      check_eq("busy_after_resp", {31'd0, bus.busy}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         resp[k] = (k < tx_q.size()) ? tx_q[k] : 8'h00;
         check_eq($sformatf("resp_byte%0d", k), resp[k], exp[k]);
      end
      if (tx_q.size() == 4) begin
         check_eq("busy_at_last_tx", {31'd0, tx_busy_q[3]}, 32'd1);
         check_eq("first_tx_latency", (tx_cyc_q[0] >= csum_cyc + (dr ? 3 : 2)), 1);
      end
      check_eq("wr_strobes", wr_a_q.size(), dw ? 1 : 0);
      check_eq("rd_strobes", rd_a_q.size(), dr ? 1 : 0);
      if (dw && wr_a_q.size() == 1) begin
         check_eq("wr_addr", wr_a_q[0], addr);
         check_eq("wr_data", wr_d_q[0], data);
         check_eq("wr_cycle", wr_c_q[0], csum_cyc + 1);
      end
      if (dr && rd_a_q.size() == 1) begin
         check_eq("rd_addr", rd_a_q[0], addr);
         check_eq("rd_cycle", rd_c_q[0], csum_cyc + 1);
      end
      if (dw || dr) check_eq("reg_addr_hold", bus.reg_addr, addr);
      check_eq("no_drop", drop_cnt - drop_base, 0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #600_000;
      $display("FAIL watchdog: simulation did not finish, got time %0t, expected completion", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int         drop_base, i;
      logic [7:0] c, a, d, s;
      reset_n           = 1'b0;
      bus.rx_data_valid = 1'b0;
      bus.rx_data       = 8'h00;
      bus.reg_rdata     = 8'h00;
      for (int k = 0; k < 256; k++) begin
         env_mem[k] = 8'(k * 7 + 3);
         mdl_mem[k] = 8'(k * 7 + 3);
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_tx_valid", {31'd0, bus.tx_data_valid}, 32'd0);
      check_eq("rst_tx_data", bus.tx_data, 8'h00);
      check_eq("rst_reg_addr", bus.reg_addr, 8'h00);
      check_eq("rst_reg_wdata", bus.reg_wdata, 8'h00);
      check_eq("rst_wr_en", {31'd0, bus.reg_wr_en}, 32'd0);
      check_eq("rst_rd_en", {31'd0, bus.reg_rd_en}, 32'd0);
      check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
      check_eq("rst_frame_drop", {31'd0, bus.frame_drop}, 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (2) @(posedge clk);

      // Write
      run_frame(8'h01, 8'h10, 8'h3C, 8'h2D, 0, 0, -1);
      check_eq("dir_wr_resp", {resp[0], resp[1], resp[2], resp[3]}, 32'h5A000000);
      // Read
      env_mem[8'h20] = 8'h77;
      mdl_mem[8'h20] = 8'h77;
      run_frame(8'h02, 8'h20, 8'h00, 8'h22, 0, 0, -1);
      check_eq("dir_rd_resp", {resp[0], resp[1], resp[2], resp[3]}, 32'h5A007777);
      // Bad checksum
      run_frame(8'h01, 8'h10, 8'h3C, 8'h00, 0, 0, -1);
      check_eq("dir_csum_resp", {resp[0], resp[1], resp[2], resp[3]}, 32'h5A010001);
      // Bad command
      run_frame(8'h07, 8'h00, 8'h00, 8'h07, 0, 0, -1);
      check_eq("dir_cmd_resp", {resp[0], resp[1], resp[2], resp[3]}, 32'h5A020002);

      // Timeout: partial frame then silence
      tx_q.delete();
      drop_base = drop_cnt;
      send_byte(8'hA5, 0);
      send_byte(8'h01, 0);
      check_eq("to_busy_mid_frame", {31'd0, bus.busy}, 32'd1);
      i = 0;
      while (drop_cnt == drop_base && i < TO + 20) begin
         @(posedge clk);
         i++;
      end
      repeat (10) @(posedge clk);
      @(negedge clk);
      check_eq("to_drop_pulses", drop_cnt - drop_base, 1);
      check_eq("to_drop_window", (drop_cyc - last_cyc >= TO - 2) && (drop_cyc - last_cyc <= TO + 3), 1);
      check_eq("to_busy_low", {31'd0, bus.busy}, 32'd0);
      check_eq("to_no_tx", tx_q.size(), 0);
      // Normal frame after timeout: read back the earlier write
      run_frame(8'h02, 8'h10, 8'h00, 8'h12, 0, 0, -1);
      check_eq("post_to_resp", {resp[0], resp[1], resp[2], resp[3]}, 32'h5A003C3C);

      // Stalled transmitter, junk before sync, stray rx bytes
      run_frame(8'h01, 8'h33, 8'hC4, 8'hF6, 1, 1, -1);
      check_eq("stall_resp", {resp[0], resp[1], resp[2], resp[3]}, 32'h5A000000);
      // Long but legal inter-byte gaps: counter must clear on every byte
      run_frame(8'h02, 8'h33, 8'h00, 8'h31, 0, 0, TO - 10);
      check_eq("long_gap_resp", {resp[0], resp[1], resp[2], resp[3]}, 32'h5A00C4C4);

      // Reset in the middle of a response
      tx_q.delete();
      send_byte(8'hA5, 0);
      send_byte(8'h02, 0);
      send_byte(8'h20, 0);
      send_byte(8'h00, 0);
      send_byte(8'h22, 0);
      i = 0;
      while (tx_q.size() < 1 && i < 100) begin
         @(posedge clk);
         #1;
         i++;
      end
      check_eq("mid_rst_started", (tx_q.size() >= 1), 1);
      #2 reset_n = 1'b0;
      #1;
      check_eq("mid_rst_tx_valid", {31'd0, bus.tx_data_valid}, 32'd0);
      check_eq("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
      check_eq("mid_rst_reg_addr", bus.reg_addr, 8'h00);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      tx_q.delete();
      repeat (30) @(posedge clk);
      check_eq("mid_rst_no_tx", tx_q.size(), 0);

      // Randomized frames
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0, 1:    c = 8'h01;
            2:       c = 8'h02;
            default: c = 8'($urandom);
         endcase
         a = 8'($urandom);
         d = 8'($urandom);
         s = c ^ a ^ d;
         if ($urandom_range(0, 4) == 0) s = s ^ 8'($urandom_range(1, 255));
         run_frame(c, a, d, s, bit'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
